// File: rtl/hex_display_scanner_if.sv
// hex_display_scanner_if: value input and display outputs of the hex scanner
interface hex_display_scanner_if;
  logic [15:0] value;
  logic [3:0] an;
  logic [6:0] seg;
  logic frame;
  modport master(output value, input an, seg, frame);
  modport slave(input value, output an, seg, frame);
endinterface

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: multiplexed 4-digit hex 7-segment scanner with frame-latched value
module hex_display_scanner #(
  parameter int DIV_WIDTH = 16,
  parameter int BLANK_CYCLES = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int BLANK_LEADING = 0
)(
  input logic clk,
  input logic arst_n,
  hex_display_scanner_if.slave bus
);
  localparam logic [3:0] AN_OFF = ACTIVE_LOW != 0 ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW != 0 ? 7'h7F : 7'h00;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [DIV_WIDTH-1:0] pre;
  logic [1:0] idx;
  logic [15:0] snap;
  logic [3:0] nib, an_d;
  logic [6:0] seg_d;
  logic load, sup, lit;
  // Decode the current scan position into the next digit drive; the load cycle sees the old snapshot
  always_comb begin
    load = pre == '0 && idx == 2'd0;
    nib = snap[{idx, 2'b00} +: 4];
    sup = BLANK_LEADING != 0 && (idx == 2'd3 ? snap[15:12] == 4'h0 :
                                 idx == 2'd2 ? snap[15:8] == 8'h00 :
                                 idx == 2'd1 ? snap[15:4] == 12'h000 : 1'b0);
    lit = int'(pre) >= BLANK_CYCLES && !sup;
    an_d = (lit ? 4'b0001 << idx : 4'h0) ^ AN_OFF;
    seg_d = (lit ? HEX[nib] : 7'h00) ^ SEG_OFF;
  end
  // Prescaler, digit index, once-per-frame snapshot and registered display outputs
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      pre <= '0;
      idx <= 2'd0;
      snap <= 16'h0000;
      bus.frame <= 1'b0;
      bus.an <= AN_OFF;
      bus.seg <= SEG_OFF;
    end else begin
      pre <= pre + 1'b1;
      if (&pre) idx <= idx + 2'd1;
      if (load) snap <= bus.value;
      bus.frame <= load;
      bus.an <= an_d;
      bus.seg <= seg_d;
    end
endmodule
